// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus per-channel debounce with registered press/release pulses.
// Optional long-press detection is compiled in when BUTTON_LONGPRESS_EN is defined.
module button_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit ACTIVE_LOW      = 1'b1
`ifdef BUTTON_LONGPRESS_EN
    ,
    parameter int LONG_CYCLES     = 25000000
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_buttons,
    output logic [WIDTH-1:0] io_state,
    output logic [WIDTH-1:0] io_pressed,
    output logic [WIDTH-1:0] io_released
`ifdef BUTTON_LONGPRESS_EN
    ,
    output logic [WIDTH-1:0] io_long
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DC_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] norm_s;
    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] state_r;
    logic [WIDTH-1:0] state_nxt_s;
    logic [WIDTH-1:0] pressed_r;
    logic [WIDTH-1:0] pressed_nxt_s;
    logic [WIDTH-1:0] released_r;
    logic [WIDTH-1:0] released_nxt_s;
    logic [CW-1:0]    cnt_r     [WIDTH];
    logic [CW-1:0]    cnt_nxt_s [WIDTH];

    // Polarity normalisation: 1 always means pressed downstream.
    assign norm_s = io_buttons ^ {WIDTH{ACTIVE_LOW}};

    // Two-flop synchronizer chain per channel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= {WIDTH{1'b0}};
            sync2_r <= {WIDTH{1'b0}};
        end else begin
            sync1_r <= norm_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce next-state: count consecutive mismatches, accept on the last one.
    always_comb begin
        state_nxt_s    = state_r;
        pressed_nxt_s  = {WIDTH{1'b0}};
        released_nxt_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (sync2_r[i] == state_r[i]) begin
                cnt_nxt_s[i] = {CW{1'b0}};
            end else if (cnt_r[i] == DC_LAST) begin
                cnt_nxt_s[i]      = {CW{1'b0}};
                state_nxt_s[i]    = sync2_r[i];
                pressed_nxt_s[i]  = sync2_r[i];
                released_nxt_s[i] = ~sync2_r[i];
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Debounce state, counters and event pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= {WIDTH{1'b0}};
            pressed_r  <= {WIDTH{1'b0}};
            released_r <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
        end else begin
            state_r    <= state_nxt_s;
            pressed_r  <= pressed_nxt_s;
            released_r <= released_nxt_s;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign io_state    = state_r;
    assign io_pressed  = pressed_r;
    assign io_released = released_r;

`ifdef BUTTON_LONGPRESS_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    logic [HW-1:0]    hold_r     [WIDTH];
    logic [HW-1:0]    hold_nxt_s [WIDTH];
    logic [WIDTH-1:0] long_r;
    logic [WIDTH-1:0] long_nxt_s;

    // Hold counter saturates, so the long pulse can fire only once per press.
    always_comb begin
        long_nxt_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            hold_nxt_s[i] = hold_r[i];
            if (!state_r[i]) begin
                hold_nxt_s[i] = {HW{1'b0}};
            end else if (hold_r[i] != HOLD_MAX) begin
                hold_nxt_s[i] = hold_r[i] + HOLD_ONE;
            end else begin
                hold_nxt_s[i] = hold_r[i];
            end
            long_nxt_s[i] = state_r[i] & (hold_r[i] == HOLD_LAST);
        end
    end

    // Hold counters and long-press pulse register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            long_r <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                hold_r[i] <= {HW{1'b0}};
            end
        end else begin
            long_r <= long_nxt_s;
            for (int i = 0; i < WIDTH; i++) begin
                hold_r[i] <= hold_nxt_s[i];
            end
        end
    end

    assign io_long = long_r;
`endif

endmodule
